// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-4 Booth multiplier retiring PP_PER_CYCLE digits per clock
module booth_mul_seq #(
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 16,
  parameter int WIDTH_O = WIDTH_A + WIDTH_B,
  parameter int PP_PER_CYCLE = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH_A-1:0] operand_a,
  input  logic [WIDTH_B-1:0] operand_b,
  input  logic               signed_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH_O-1:0] product_o,
  output logic               busy_o
);
  localparam int COUNT = (WIDTH_B + 2) / 2;
  localparam int N_ITER = (COUNT + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
  localparam int ACCW = WIDTH_A + WIDTH_B + 2;
  localparam int BW = 2 * COUNT + 1;
  localparam int IW = $clog2(N_ITER + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  if (PP_PER_CYCLE < 1 || PP_PER_CYCLE > COUNT) begin : g_bad_pp
    $error("booth_mul_seq: PP_PER_CYCLE must be in 1..COUNT");
  end
  state_t            r_state, w_next;
  logic [ACCW-1:0]   r_acc, r_m, w_sum, w_mag, w_pp;
  logic [BW-1:0]     r_b;
  logic [IW-1:0]     r_iter;
  logic [WIDTH_O-1:0] r_prod;
  logic [2:0]        w_d;
  logic              w_accept, w_last;
  assign w_accept = r_state == IDLE && in_valid_i;
  assign w_last = r_state == BUSY && r_iter == IW'(N_ITER - 1);
  assign in_ready_o = r_state == IDLE;
  assign out_valid_o = r_state == DONE;
  assign busy_o = r_state != IDLE;
  assign product_o = r_prod;
  always_ff @(posedge clk_i)
    r_state <= rst_i ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && in_valid_i) w_next = BUSY;
    if (w_last) w_next = DONE;
    if (r_state == DONE && out_ready_i) w_next = IDLE;
  end
  // r_m and r_b advance by 2*PP_PER_CYCLE bits per cycle, so digit k always sits at r_b[2k+2:2k]
  always_comb begin
    w_sum = r_acc;
    w_d = '0;
    w_mag = '0;
    w_pp = '0;
    for (int k = 0; k < PP_PER_CYCLE; k++) begin
      w_d = r_b[2*k +: 3];
      w_mag = (w_d == 3'b011 || w_d == 3'b100) ? r_m << 1 : r_m;
      w_pp = (w_d == 3'b000 || w_d == 3'b111 || int'(r_iter) * PP_PER_CYCLE + k >= COUNT) ? '0 :
             w_d[2] ? -w_mag : w_mag;
      w_sum = w_sum + (w_pp << (2 * k));
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc <= '0;
      r_m <= '0;
      r_b <= '0;
      r_iter <= '0;
      r_prod <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_m <= {{(ACCW-WIDTH_A){signed_i & operand_a[WIDTH_A-1]}}, operand_a};
      r_b <= {{(BW-1-WIDTH_B){signed_i & operand_b[WIDTH_B-1]}}, operand_b, 1'b0};
      r_iter <= '0;
    end else if (r_state == BUSY) begin
      r_acc <= w_sum;
      r_m <= r_m << (2 * PP_PER_CYCLE);
      r_b <= r_b >> (2 * PP_PER_CYCLE);
      r_iter <= r_iter + 1'b1;
      if (w_last) r_prod <= w_sum[WIDTH_O-1:0];
    end
  end
endmodule

// File: doc/booth_mul_seq.md
# booth_mul_seq

Iterative, parametrised radix-4 Booth multiplier with a valid/ready handshake and selectable signed or unsigned mode. It retires `PP_PER_CYCLE` Booth partial products per clock into an internal accumulator, so area can be traded against latency. It feeds a resolved product into the posit datapath (mantissa multiply stage) wherever a full-width combinational multiplier plus CSA tree is too costly.

## Interface
- `WIDTH_A`, 16: multiplicand width.
- `WIDTH_B`, 16: multiplier width.
- `WIDTH_O`, `WIDTH_A+WIDTH_B`: product width. If smaller, the low `WIDTH_O` bits are kept.
- `PP_PER_CYCLE`, 1: Booth digits accumulated per cycle. Legal range is 1..`COUNT`; elaboration error otherwise.
- Derived: `COUNT = (WIDTH_B+2)/2` (integer division) and `N_ITER = ceil(COUNT/PP_PER_CYCLE)`.

Ports:
- `clk_i`, in, 1: clock. One clock domain, all logic on the rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `in_valid_i`, in, 1: operands valid.
- `in_ready_o`, out, 1: block can accept operands.
- `operand_a`, in, `WIDTH_A`: multiplicand.
- `operand_b`, in, `WIDTH_B`: multiplier.
- `signed_i`, in, 1: 1 means two's-complement operands; 0 means unsigned.
- `out_valid_o`, out, 1: product valid.
- `out_ready_i`, in, 1: consumer accepts the product.
- `product_o`, out, `WIDTH_O`: product.
- `busy_o`, out, 1: a multiply is in flight (state BUSY or DONE).

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE to BUSY when `in_valid_i && in_ready_o`.
  - BUSY to DONE after `N_ITER` accumulation cycles.
  - DONE to IDLE when `out_ready_i`.
- Capture on accept:
  - A is extended by 2 bits to `WIDTH_A+2`, using sign-extension if `signed_i` else zero-extension, so ±2A is exact.
  - B is extended to `2*COUNT+1` bits: one implicit 0 below the LSB, and the upper bits sign- or zero-extended by `signed_i`.
  - `signed_i` is latched and ignored after accept.
- Digit `i` (0..`COUNT`-1) is recoded from extended-B bits {b[2i+1], b[2i], b[2i-1]} to a value in {-2,-1,0,+1,+2}. Its partial product is digit·A shifted left 2i.
- Accumulator:
  - Width is `WIDTH_A+WIDTH_B+2`, two's complement, cleared on accept.
  - Each BUSY cycle adds the next `PP_PER_CYCLE` digits' partial products.
  - The final iteration may hold fewer digits; missing digits count as 0.
- `product_o` is the low `WIDTH_O` bits of the accumulator. It is exact for both modes when `WIDTH_O = WIDTH_A+WIDTH_B`.
- `product_o` is registered, driven only in DONE, and held stable until the handshake. In other states it holds its last value; the value is don't-care.
- Handshake:
  - `in_ready_o = (state==IDLE)`, decoded from the state register only. There is no combinational path from `out_ready_i`.
  - `out_valid_o = (state==DONE)`.
  - `out_valid_o`, once high, stays high until `out_ready_i` is sampled high.
- Operands and `in_valid_i` presented outside IDLE are ignored; nothing is queued.

## Timing
- Reset:
  - Takes effect at the rising edge while `rst_i=1`, and has priority over every transition.
  - State goes to IDLE; the accumulator and `product_o` go to 0.
  - Outputs after reset: `out_valid_o=0`, `busy_o=0`, `in_ready_o=1`.
- Reset mid-operation (BUSY or DONE): the in-flight result is discarded and no `out_valid_o` pulse occurs.
- Latency: accept at edge E0, accumulation at edges E1..E`N_ITER`. `out_valid_o=1` in the cycle after edge E`N_ITER`.
  - 16x16 with `PP_PER_CYCLE=1`: `N_ITER=9`.
  - 16x16 with `PP_PER_CYCLE=3`: `N_ITER=3`.
  - 16x16 with `PP_PER_CYCLE=9`: `N_ITER=1`.
- Output handshake at edge Ed returns the FSM to IDLE. `in_ready_o=1` in the next cycle.
- Peak throughput is one product per `N_ITER+2` cycles.
- `in_valid_i` may rise while `in_ready_o=0`. Acceptance occurs at the first edge where both are high.
- Inputs are sampled only at the accept edge and may change freely afterwards.

## Test plan
- Unsigned max, `PP_PER_CYCLE=1`: A=0xFFFF, B=0xFFFF, `signed_i=0` → `product_o=0xFFFE0001`, with `out_valid_o` high exactly 9 cycles after accept.
- Signed corners: -1×-1 → 0x00000001; 0x8000×0x8000 → 0x40000000; 0x8000×0x7FFF → 0xC0008000; 0×0x8000 → 0.
- Backpressure: hold `out_ready_i=0` for 5 cycles with A=3, B=5 →
  - `product_o=15` stable with `out_valid_o=1` throughout and `in_ready_o=0`;
  - a new `in_valid_i` is not accepted until the cycle after `out_ready_i` rises.
- Reset mid-BUSY: assert `rst_i` at iteration 4 →
  - next cycle `out_valid_o=0`, `busy_o=0`, `in_ready_o=1`, `product_o=0`;
  - a following 7×9 multiply returns 63 with full latency.
- Parameter sweep with `PP_PER_CYCLE` ∈ {1,3,9}, plus an odd case with `WIDTH_B=15` and `PP_PER_CYCLE=2` (`COUNT=8`, `N_ITER=4`) → latencies are 9/3/1/4.
- Random: 10k vectors per mode with randomized `out_ready_i` and `in_valid_i` → every product matches the reference model and no handshake is lost or duplicated.
